shape_fill_engine: RTL and testbench

- Parametrised successor to the board/chess pixel painter.
- Accepts queued draw commands, each a bounding box, a fill mode and a colour, and rasterises them into a framebuffer write stream (pix_x, pix_y, pix_color, pix_we).
- Adds a command FIFO, a valid/ready handshake, outline and circle modes with an exact integer test, an abort input, and a per-command done pulse.
- Sits between game-level painting control and the VGA framebuffer write port.

---
 rtl/shape_fill_pkg.sv | 47 ++++
 rtl/shape_fill_engine_cmd_fifo.sv | 54 +++++
 rtl/shape_fill_engine.sv | 210 +++++++++++++++++++++
 tb/tb_shape_fill_engine.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shape_fill_pkg.sv
// shape_fill_pkg: mode codes, FSM encoding and command record layout for shape_fill_engine.
// Rev 1.0
`default_nettype none

package shape_fill_pkg;

  localparam logic [1:0] MODE_FILL    = 2'd0;
  localparam logic [1:0] MODE_OUTLINE = 2'd1;
  localparam logic [1:0] MODE_CIRCLE  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TEST  = 3'd2,
    ST_WRITE = 3'd3,
    ST_GAP   = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  // Record packs as {x0, y0, x1, y1, mode, color}, colour in the LSBs.
  function automatic int cmd_off_mode(input int cb);
    return cb;
  endfunction

  function automatic int cmd_off_y1(input int cb);
    return cb + 2;
  endfunction

  function automatic int cmd_off_x1(input int yb, input int cb);
    return cb + 2 + yb;
  endfunction

  function automatic int cmd_off_y0(input int xb, input int yb, input int cb);
    return cb + 2 + yb + xb;
  endfunction

  function automatic int cmd_off_x0(input int xb, input int yb, input int cb);
    return cb + 2 + 2 * yb + xb;
  endfunction

  function automatic int cmd_width(input int xb, input int yb, input int cb);
    return cb + 2 + 2 * (xb + yb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shape_fill_engine_cmd_fifo.sv
// cmd_fifo: registered command queue with push, pop, flush and full/empty flags.
// Rev 1.0
`default_nettype none

module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB separates full from empty when the indices match.
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_data    = r_mem[r_rd[AW-1:0]];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/shape_fill_engine.sv
// shape_fill_engine: rasterises queued FILL / OUTLINE / CIRCLE box commands into a framebuffer write stream.
// Rev 1.0
`default_nettype none

module shape_fill_engine
  import shape_fill_pkg::*;
#(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_BITS = 3,
  parameter int WR_HOLD    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_BITS-1:0]     cmd_x0,
  input  logic [Y_BITS-1:0]     cmd_y0,
  input  logic [X_BITS-1:0]     cmd_x1,
  input  logic [Y_BITS-1:0]     cmd_y1,
  input  logic [1:0]            cmd_mode,
  input  logic [COLOR_BITS-1:0] cmd_color,
  input  logic                  abort,
  output logic [X_BITS-1:0]     pix_x,
  output logic [Y_BITS-1:0]     pix_y,
  output logic [COLOR_BITS-1:0] pix_color,
  output logic                  pix_we,
  output logic                  busy,
  output logic                  done
);

  localparam int CMD_W   = cmd_width(X_BITS, Y_BITS, COLOR_BITS);
  localparam int OFF_MD  = cmd_off_mode(COLOR_BITS);
  localparam int OFF_Y1  = cmd_off_y1(COLOR_BITS);
  localparam int OFF_X1  = cmd_off_x1(Y_BITS, COLOR_BITS);
  localparam int OFF_Y0  = cmd_off_y0(X_BITS, Y_BITS, COLOR_BITS);
  localparam int OFF_X0  = cmd_off_x0(X_BITS, Y_BITS, COLOR_BITS);
  localparam int MB      = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
  localparam int DW      = MB + 2;
  localparam int SW      = 2 * DW;
  localparam int HW      = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  state_t r_state, w_state_n;

  logic [CMD_W-1:0]      w_cmd_in, w_head;
  logic                  w_full, w_empty, w_push, w_pop;
  logic [X_BITS-1:0]     r_x0, r_x1, r_x, r_pix_x;
  logic [Y_BITS-1:0]     r_y0, r_y1, r_y, r_pix_y;
  logic [1:0]            r_mode;
  logic [COLOR_BITS-1:0] r_color, r_pix_color;
  logic [X_BITS:0]       r_cx, w_sx;
  logic [Y_BITS:0]       r_cy, w_sy;
  logic [SW-1:0]         r_r2, w_re, w_dx2, w_dy2;
  logic [HW-1:0]         r_hold;
  logic [MB-1:0]         w_wx, w_wy, w_r;
  logic signed [DW-1:0]  w_dx, w_dy;
  logic signed [SW-1:0]  w_dxs, w_dys;
  logic [SW:0]           w_dist;
  logic                  w_in_circ, w_incl, w_last, w_degen;

  assign w_cmd_in  = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_mode, cmd_color};
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready && !abort;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty && !abort;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (Clck),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .i_flush (abort),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Geometry set up during LOAD from the latched command.
  assign w_sx    = {1'b0, r_x0} + {1'b0, r_x1};
  assign w_sy    = {1'b0, r_y0} + {1'b0, r_y1};
  assign w_wx    = MB'(r_x1 - r_x0);
  assign w_wy    = MB'(r_y1 - r_y0);
  assign w_r     = ((w_wx < w_wy) ? w_wx : w_wy) >> 1;
  assign w_re    = SW'(w_r);
  assign w_degen = (r_x1 < r_x0) || (r_y1 < r_y0);

  // Exact circle test: widened signed differences, unsigned sum one bit wider.
  assign w_dx      = $signed(DW'(r_x) - DW'(r_cx));
  assign w_dy      = $signed(DW'(r_y) - DW'(r_cy));
  assign w_dxs     = SW'(w_dx);
  assign w_dys     = SW'(w_dy);
  assign w_dx2     = $unsigned(w_dxs * w_dxs);
  assign w_dy2     = $unsigned(w_dys * w_dys);
  assign w_dist    = {1'b0, w_dx2} + {1'b0, w_dy2};
  assign w_in_circ = (w_dist <= {1'b0, r_r2});
  assign w_last    = (r_x == r_x1) && (r_y == r_y1);

  always_comb begin
    w_incl = 1'b1;
    case (r_mode)
      MODE_OUTLINE: w_incl = (r_x == r_x0) || (r_x == r_x1) || (r_y == r_y0) || (r_y == r_y1);
      MODE_CIRCLE:  w_incl = w_in_circ;
      default:      w_incl = 1'b1;
    endcase
  end

  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    pix_we    = (r_state == ST_WRITE);
    done      = (r_state == ST_FIN);
    busy      = (r_state != ST_IDLE) || !w_empty;
    if (abort) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (!w_empty) w_state_n = ST_LOAD;
        ST_LOAD:  w_state_n = w_degen ? ST_FIN : ST_TEST;
        ST_TEST:  w_state_n = w_incl ? ST_WRITE : (w_last ? ST_FIN : ST_TEST);
        ST_WRITE: if (r_hold == HW'(WR_HOLD - 1)) w_state_n = ST_GAP;
        ST_GAP:   w_state_n = w_last ? ST_FIN : ST_TEST;
        ST_FIN:   w_state_n = ST_IDLE;
        default:  w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_mode      <= '0;
      r_color     <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_r2        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_hold      <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_color <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_x0    <= w_head[OFF_X0 +: X_BITS];
            r_y0    <= w_head[OFF_Y0 +: Y_BITS];
            r_x1    <= w_head[OFF_X1 +: X_BITS];
            r_y1    <= w_head[OFF_Y1 +: Y_BITS];
            r_mode  <= w_head[OFF_MD +: 2];
            r_color <= w_head[0 +: COLOR_BITS];
          end
        end
        ST_LOAD: begin
          r_cx <= w_sx >> 1;
          r_cy <= w_sy >> 1;
          r_r2 <= w_re * w_re;
          r_x  <= r_x0;
          r_y  <= r_y0;
        end
        ST_TEST: begin
          if (w_incl) begin
            r_pix_x     <= r_x;
            r_pix_y     <= r_y;
            r_pix_color <= r_color;
            r_hold      <= '0;
          end else if (!w_last) begin
            if (r_x == r_x1) begin
              r_x <= r_x0;
              r_y <= r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        ST_WRITE: r_hold <= r_hold + 1'b1;
        ST_GAP: begin
          // The last pixel is never advanced past, so x1/y1 at full scale cannot wrap.
          if (!w_last) begin
            if (r_x == r_x1) begin
              r_x <= r_x0;
              r_y <= r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_color = r_pix_color;

endmodule

`default_nettype wire

// File: tb/tb_shape_fill_engine.sv
// tb_shape_fill_engine: directed self-checking bench for shape_fill_engine.
// Rev 1.0
`default_nettype none

module tb_shape_fill_engine;

  logic       Clck = 1'b0;
  logic       Reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [6:0] cmd_y0 = '0, cmd_y1 = '0;
  logic [1:0] cmd_mode = '0;
  logic [2:0] cmd_color = '0;
  logic       abort = 1'b0;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_color;
  logic       pix_we, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int wx[$], wy[$], wc[$], wcyc[$], wwid[$], dcyc[$];
  int   run = 0;
  logic prev_we = 1'b0;

  shape_fill_engine #(
    .X_BITS(8), .Y_BITS(7), .COLOR_BITS(3), .WR_HOLD(3), .FIFO_DEPTH(4)
  ) dut (
    .Clck(Clck), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_mode(cmd_mode), .cmd_color(cmd_color), .abort(abort),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_we(pix_we), .busy(busy), .done(done)
  );

  always #5 Clck = ~Clck;

  always @(posedge Clck) cyc++;

  // Record every write pulse (start cycle, coordinates, width) and every done pulse.
  always @(negedge Clck) begin
    if (pix_we && !prev_we) begin
      wx.push_back(int'(pix_x));
      wy.push_back(int'(pix_y));
      wc.push_back(int'(pix_color));
      wcyc.push_back(cyc);
      run = 1;
    end else if (pix_we) begin
      run++;
    end
    if (!pix_we && prev_we) wwid.push_back(run);
    if (done) dcyc.push_back(cyc);
    prev_we = pix_we;
  end

  task automatic clear_log();
    wx.delete(); wy.delete(); wc.delete(); wcyc.delete(); wwid.delete(); dcyc.delete();
  endtask

  task automatic push_cmd(input int x0, input int y0, input int x1, input int y1,
                          input int md, input int col, output int acc);
    int t;
    @(negedge Clck);
    cmd_x0 = x0[7:0]; cmd_y0 = y0[6:0]; cmd_x1 = x1[7:0]; cmd_y1 = y1[6:0];
    cmd_mode = md[1:0]; cmd_color = col[2:0];
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge Clck);
      t++;
    end
    acc = cyc + 1;
    @(posedge Clck);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge Clck);
    while (busy && t < 5000) begin
      @(negedge Clck);
      t++;
    end
    repeat (3) @(negedge Clck);
    n_checks++;
    if (t >= 5000) $display("FAIL %s_timeout: busy still %0b, required 0", name, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #12;
    n_checks++;
    if ({pix_x, pix_y, pix_color, pix_we, busy, done, cmd_ready} !== {8'd0, 7'd0, 3'd0, 3'b000, 1'b1})
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d we=%0b busy=%0b done=%0b rdy=%0b, required all 0 with rdy=1",
               pix_x, pix_y, pix_color, pix_we, busy, done, cmd_ready);
    else n_pass++;
    @(negedge Clck);
    Reset = 1'b0;
  endtask

  task automatic test_fill();
    int acc;
    int ex[6] = '{2, 3, 4, 2, 3, 4};
    int ey[6] = '{3, 3, 3, 4, 4, 4};
    clear_log();
    push_cmd(2, 3, 4, 4, 0, 5, acc);
    wait_idle("fill");
    n_checks++;
    if (wx.size() != 6) $display("FAIL fill_count: got %0d writes, required 6", wx.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < wx.size(); i++) begin
      n_checks++;
      if (wx[i] != ex[i] || wy[i] != ey[i] || wc[i] != 5 || wcyc[i] != acc + 3 + 5 * i || wwid[i] != 3)
        $display("FAIL fill_px%0d: got (%0d,%0d) c=%0d at %0d width %0d, required (%0d,%0d) c=5 at %0d width 3",
                 i, wx[i], wy[i], wc[i], wcyc[i] - acc, wwid[i], ex[i], ey[i], 3 + 5 * i);
      else n_pass++;
    end
    n_checks++;
    if (dcyc.size() != 1 || dcyc[0] != acc + 32)
      $display("FAIL fill_done: got %0d pulses, first at +%0d, required 1 at +32", dcyc.size(), dcyc[0] - acc);
    else n_pass++;
  endtask

  task automatic test_outline();
    int acc;
    int ex[12] = '{0, 1, 2, 3, 0, 3, 0, 3, 0, 1, 2, 3};
    int ey[12] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
    int bad;
    clear_log();
    push_cmd(0, 0, 3, 3, 1, 2, acc);
    wait_idle("outline");
    n_checks++;
    if (wx.size() != 12) $display("FAIL outline_count: got %0d writes, required 12", wx.size());
    else n_pass++;
    bad = -1;
    for (int i = 0; i < 12 && i < wx.size(); i++)
      if (bad < 0 && (wx[i] != ex[i] || wy[i] != ey[i] || wc[i] != 2)) bad = i;
    n_checks++;
    if (bad >= 0)
      $display("FAIL outline_order: write %0d got (%0d,%0d) c=%0d, required (%0d,%0d) c=2",
               bad, wx[bad], wy[bad], wc[bad], ex[bad], ey[bad]);
    else n_pass++;
    n_checks++;
    if (dcyc.size() != 1 || dcyc[0] != acc + 66)
      $display("FAIL outline_done: got %0d pulses, first at +%0d, required 1 at +66", dcyc.size(), dcyc[0] - acc);
    else n_pass++;
  endtask

  task automatic test_circle();
    int acc;
    int ex[13] = '{12, 11, 12, 13, 10, 11, 12, 13, 14, 11, 12, 13, 12};
    int ey[13] = '{10, 11, 11, 11, 12, 12, 12, 12, 12, 13, 13, 13, 14};
    int bad;
    clear_log();
    push_cmd(10, 10, 14, 14, 2, 7, acc);
    wait_idle("circle");
    n_checks++;
    if (wx.size() != 13) $display("FAIL circle_count: got %0d writes, required 13", wx.size());
    else n_pass++;
    bad = -1;
    for (int i = 0; i < 13 && i < wx.size(); i++)
      if (bad < 0 && (wx[i] != ex[i] || wy[i] != ey[i] || wc[i] != 7)) bad = i;
    n_checks++;
    if (bad >= 0)
      $display("FAIL circle_order: write %0d got (%0d,%0d) c=%0d, required (%0d,%0d) c=7",
               bad, wx[bad], wy[bad], wc[bad], ex[bad], ey[bad]);
    else n_pass++;
    n_checks++;
    if (dcyc.size() != 1 || dcyc[0] != acc + 79)
      $display("FAIL circle_done: got %0d pulses, first at +%0d, required 1 at +79", dcyc.size(), dcyc[0] - acc);
    else n_pass++;
  endtask

  task automatic test_boundary();
    int acc;
    clear_log();
    push_cmd(5, 0, 4, 0, 0, 1, acc);
    wait_idle("degenerate");
    n_checks++;
    if (wx.size() != 0 || dcyc.size() != 1 || dcyc[0] != acc + 2)
      $display("FAIL degenerate: got %0d writes, %0d dones at +%0d, required 0 writes, 1 done at +2",
               wx.size(), dcyc.size(), dcyc[0] - acc);
    else n_pass++;
    clear_log();
    push_cmd(255, 127, 255, 127, 0, 6, acc);
    wait_idle("maxcoord");
    n_checks++;
    if (wx.size() != 1 || wx[0] != 255 || wy[0] != 127 || wc[0] != 6)
      $display("FAIL maxcoord_write: got %0d writes, first (%0d,%0d) c=%0d, required 1 at (255,127) c=6",
               wx.size(), wx[0], wy[0], wc[0]);
    else n_pass++;
    n_checks++;
    if (dcyc.size() != 1 || dcyc[0] != acc + 7)
      $display("FAIL maxcoord_done: got %0d pulses at +%0d, required 1 at +7", dcyc.size(), dcyc[0] - acc);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc0, acc;
    clear_log();
    push_cmd(0, 20, 0, 20, 0, 1, acc0);
    for (int k = 1; k < 5; k++) push_cmd(k, 20 + k, k, 20 + k, 0, k + 1, acc);
    n_checks++;
    if (cmd_ready !== 1'b0 || acc != acc0 + 4)
      $display("FAIL b2b_ready: got rdy=%0b last accept at +%0d, required rdy=0 and +4", cmd_ready, acc - acc0);
    else n_pass++;
    wait_idle("b2b");
    n_checks++;
    if (wx.size() != 5 || dcyc.size() != 5)
      $display("FAIL b2b_count: got %0d writes %0d dones, required 5 and 5", wx.size(), dcyc.size());
    else n_pass++;
    for (int k = 0; k < 5 && k < wx.size() && k < dcyc.size(); k++) begin
      n_checks++;
      if (wx[k] != k || wy[k] != 20 + k || wc[k] != k + 1 || dcyc[k] != acc0 + 7 + 8 * k)
        $display("FAIL b2b_cmd%0d: got (%0d,%0d) c=%0d done +%0d, required (%0d,%0d) c=%0d done +%0d",
                 k, wx[k], wy[k], wc[k], dcyc[k] - acc0, k, 20 + k, k + 1, 7 + 8 * k);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int acc, a1, a2;
    clear_log();
    push_cmd(0, 0, 3, 0, 0, 1, acc);
    push_cmd(0, 1, 3, 1, 0, 2, a1);
    push_cmd(0, 2, 3, 2, 0, 3, a2);
    while (cyc < acc + 9) @(negedge Clck);
    n_checks++;
    if (pix_we !== 1'b1 || pix_x !== 8'd1) $display("FAIL abort_pre: got we=%0b x=%0d, required we=1 x=1", pix_we, pix_x);
    else n_pass++;
    abort = 1'b1;
    cmd_x0 = 8'd50; cmd_y0 = 7'd50; cmd_x1 = 8'd50; cmd_y1 = 7'd50; cmd_mode = 2'd0; cmd_color = 3'd4;
    cmd_valid = 1'b1;
    @(posedge Clck);
    #1;
    abort = 1'b0;
    cmd_valid = 1'b0;
    n_checks++;
    if (pix_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL abort_post: got we=%0b busy=%0b rdy=%0b, required 0 0 1", pix_we, busy, cmd_ready);
    else n_pass++;
    repeat (40) @(negedge Clck);
    n_checks++;
    if (wx.size() != 2 || dcyc.size() != 0)
      $display("FAIL abort_flush: got %0d writes %0d dones, required 2 and 0", wx.size(), dcyc.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int acc, t, nw;
    clear_log();
    push_cmd(0, 0, 3, 0, 0, 5, acc);
    push_cmd(0, 1, 3, 1, 0, 6, acc);
    t = 0;
    while (!pix_we && t < 50) begin
      @(negedge Clck);
      t++;
    end
    #2 Reset = 1'b1;
    #1;
    nw = wx.size();
    n_checks++;
    if (pix_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || t >= 50)
      $display("FAIL reset_mid: got we=%0b busy=%0b done=%0b rdy=%0b wait=%0d, required 0 0 0 1 and wait<50",
               pix_we, busy, done, cmd_ready, t);
    else n_pass++;
    @(negedge Clck);
    Reset = 1'b0;
    repeat (30) @(negedge Clck);
    n_checks++;
    if (wx.size() != nw || dcyc.size() != 0)
      $display("FAIL reset_mid_quiet: got %0d writes %0d dones after reset, required %0d and 0",
               wx.size(), dcyc.size(), nw);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_outline();
    test_circle();
    test_boundary();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
